// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : shift_unit
//  Purpose  : Multi-cycle barrel-free shifter. One 1-bit step per clock on a
//             working register, for logical/arithmetic shifts and (optionally)
//             rotates. Result, carry-out and overflow are registered on
//             completion and held until the next accepted request.
//  Config   : SHIFT_UNIT_ROTATE_EN - when defined, ROL (011) and ROR (110)
//             are implemented; otherwise those codes act as pass-through and
//             no rotate logic is built.
//  Ports    :
//    clk      in   1      clock, rising edge
//    reset    in   1      asynchronous active-high reset
//    start    in   1      operation request (sampled in IDLE only)
//    sh       in   3      mode: 000 pass, 001 LSR, 010 LSL, 101 ASR,
//                               011 ROL, 110 ROR
//    amt      in   AMT_W  shift distance
//    in       in   WIDTH  operand
//    out      out  WIDTH  registered result
//    cout     out  1      last bit shifted/rotated out
//    overflow out  1      mode-dependent overflow flag
//    busy     out  1      high while shifting
//    done     out  1      one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       sh,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] SH_LSR = 3'b001;
  localparam logic [2:0] SH_LSL = 3'b010;
  localparam logic [2:0] SH_ASR = 3'b101;
`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [2:0] SH_ROL = 3'b011;
  localparam logic [2:0] SH_ROR = 3'b110;
`endif

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] work;
  logic [2:0]       mode;
  logic [AMT_W-1:0] count;
  logic             ovf_acc;

  // Codes that actually move bits; everything else collapses to a
  // zero-length operation (pass-through).
  logic             shifting_mode;
  logic [AMT_W-1:0] n_eff;

  always_comb begin
    shifting_mode = 1'b0;
    case (sh)
      SH_LSR, SH_LSL, SH_ASR: shifting_mode = 1'b1;
`ifdef SHIFT_UNIT_ROTATE_EN
      SH_ROL, SH_ROR:         shifting_mode = 1'b1;
`endif
      default:                shifting_mode = 1'b0;
    endcase
  end

  assign n_eff = shifting_mode ? amt : '0;

  // Single-bit step on the working register.
  logic [WIDTH-1:0] step_val;
  logic             step_out;
  logic             step_ovf;

  always_comb begin
    step_val = work;
    step_out = 1'b0;
    case (mode)
      SH_LSR: begin
        step_val = {1'b0, work[WIDTH-1:1]};
        step_out = work[0];
      end
      SH_LSL: begin
        step_val = {work[WIDTH-2:0], 1'b0};
        step_out = work[WIDTH-1];
      end
      SH_ASR: begin
        step_val = {work[WIDTH-1], work[WIDTH-1:1]};
        step_out = work[0];
      end
`ifdef SHIFT_UNIT_ROTATE_EN
      SH_ROL: begin
        step_val = {work[WIDTH-2:0], work[WIDTH-1]};
        step_out = work[WIDTH-1];
      end
      SH_ROR: begin
        step_val = {work[0], work[WIDTH-1:1]};
        step_out = work[0];
      end
`endif
      default: begin
        step_val = work;
        step_out = 1'b0;
      end
    endcase
  end

  // LSL overflow: the sign bit changed on this step.
  assign step_ovf = (mode == SH_LSL) && (work[WIDTH-1] ^ step_val[WIDTH-1]);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n_eff != '0) ? SHIFT : DONE;
      SHIFT:   if (count == CNT_ONE) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work     <= '0;
      mode     <= '0;
      count    <= '0;
      ovf_acc  <= 1'b0;
      out      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= in;
            mode  <= sh;
            count <= n_eff;
            // LSR reports the operand sign; LSL accumulates from zero.
            ovf_acc <= (sh == SH_LSR) && (n_eff != '0) && in[WIDTH-1];
            if (n_eff == '0) begin
              // Zero-length operation enters DONE directly.
              out      <= in;
              cout     <= 1'b0;
              overflow <= 1'b0;
            end
          end
        end
        SHIFT: begin
          work    <= step_val;
          count   <= count - CNT_ONE;
          ovf_acc <= ovf_acc | step_ovf;
          if (count == CNT_ONE) begin
            out      <= step_val;
            cout     <= step_out;
            overflow <= ovf_acc | step_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
